// File: rtl/map_sst_seq_pkg.sv
// rtl/map_sst_seq_pkg.sv - shared state encoding and constants for the save-state sequencer
package map_sst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SV_SET,
        SV_PUSH,
        LD_GET,
        LD_ARM,
        LD_FALL,
        FIN
    } state_t;

    localparam logic [7:0] SST_MAP_IDX_ADDR = 8'd127;

    // States in which a load write is waiting on M2 and the timeout runs
    function automatic logic is_load_wait(input state_t s);
        return (s == LD_ARM) || (s == LD_FALL);
    endfunction

endpackage

// File: rtl/map_sst_seq_m2_edge_sync.sv
// rtl/map_sst_seq_m2_edge_sync.sv - brings raw CPU M2 into the clk domain and flags its edges
module m2_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_m2,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_m2;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_prev;
    assign o_fall = ~r_s2 & r_prev;

endmodule

// File: rtl/map_sst_seq.sv
// rtl/map_sst_seq.sv - walks mapper save-state registers, streaming bytes out (save) or in (load)
module map_sst_seq
    import map_sst_seq_pkg::*;
#(
    parameter int REG_CNT    = 128,
    parameter int M2_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m2,
    input  logic       cmd_save,
    input  logic       cmd_load,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       sst_act,
    output logic [7:0] sst_addr,
    output logic       sst_we_reg,
    output logic [7:0] sst_dato,
    input  logic [7:0] sst_di,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam logic [7:0] LAST_ADDR = 8'(REG_CNT - 1);
    localparam int TO_W = $clog2(M2_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(M2_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_addr;
    logic [7:0]      r_dato;
    logic [7:0]      r_tx_data;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    logic w_m2_rise;
    logic w_m2_fall;
    logic w_last;
    logic w_timeout;
    logic w_reject;

    m2_edge_sync u_m2_sync (
        .clk    (clk),
        .rst    (rst),
        .i_m2   (m2),
        .o_rise (w_m2_rise),
        .o_fall (w_m2_fall)
    );

    assign w_last    = (r_addr == LAST_ADDR);
    assign w_timeout = is_load_wait(r_state) && (r_to_cnt == TO_LAST);
    assign w_reject  = (r_state == IDLE) && cmd_save && cmd_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b0;
        sst_act    = 1'b0;
        done       = 1'b0;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
        sst_we_reg = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_save && !cmd_load) begin
                    w_next = SV_SET;
                end else if (cmd_load && !cmd_save) begin
                    w_next = LD_GET;
                end
            end
            SV_SET: begin
                busy    = 1'b1;
                sst_act = 1'b1;
                w_next  = SV_PUSH;
            end
            SV_PUSH: begin
                busy     = 1'b1;
                sst_act  = 1'b1;
                tx_valid = 1'b1;
                if (tx_ready) begin
                    w_next = w_last ? FIN : SV_SET;
                end
            end
            LD_GET: begin
                busy     = 1'b1;
                sst_act  = 1'b1;
                rx_ready = 1'b1;
                if (rx_valid) begin
                    w_next = LD_ARM;
                end
            end
            LD_ARM: begin
                busy       = 1'b1;
                sst_act    = 1'b1;
                sst_we_reg = 1'b1;
                if (w_timeout) begin
                    w_next = IDLE;
                end else if (w_m2_rise) begin
                    w_next = LD_FALL;
                end
            end
            LD_FALL: begin
                busy       = 1'b1;
                sst_act    = 1'b1;
                sst_we_reg = 1'b1;
                if (w_timeout) begin
                    w_next = IDLE;
                end else if (w_m2_fall) begin
                    w_next = w_last ? FIN : LD_GET;
                end
            end
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= 8'd0;
            r_dato    <= 8'd0;
            r_tx_data <= 8'd0;
            r_to_cnt  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_reject || w_timeout;
            case (r_state)
                IDLE: begin
                    r_addr <= 8'd0;
                end
                SV_SET: begin
                    // sst_di has had a full cycle to settle on the new address
                    r_tx_data <= sst_di;
                end
                SV_PUSH: begin
                    if (tx_ready && !w_last) begin
                        r_addr <= r_addr + 8'd1;
                    end
                end
                LD_GET: begin
                    if (rx_valid) begin
                        r_dato   <= rx_data;
                        r_to_cnt <= '0;
                    end
                end
                LD_ARM, LD_FALL: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (w_timeout) begin
                        r_addr <= 8'd0;
                    end else if (r_state == LD_FALL && w_m2_fall && !w_last) begin
                        r_addr <= r_addr + 8'd1;
                    end
                end
                FIN: begin
                    r_addr <= 8'd0;
                end
                default: begin
                    r_addr <= 8'd0;
                end
            endcase
        end
    end

    assign err      = r_err;
    assign sst_addr = r_addr;
    assign sst_dato = r_dato;
    assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_map_sst_seq.sv
// tb/tb_map_sst_seq.sv - directed bench for the save-state sequencer with a small mapper model
module tb_map_sst_seq;
    import map_sst_seq_pkg::*;

    localparam int REG_CNT = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       m2;
    logic       m2_en;
    logic       cmd_save;
    logic       cmd_load;
    logic       busy;
    logic       done;
    logic       err;
    logic       sst_act;
    logic [7:0] sst_addr;
    logic       sst_we_reg;
    logic [7:0] sst_dato;
    logic [7:0] sst_di;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:255];
    logic [1:0] prg_reg;
    logic [3:0] chr_reg;

    map_sst_seq #(.REG_CNT(REG_CNT), .M2_TIMEOUT(4096)) dut (
        .clk        (clk),
        .rst        (rst),
        .m2         (m2),
        .cmd_save   (cmd_save),
        .cmd_load   (cmd_load),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sst_act    (sst_act),
        .sst_addr   (sst_addr),
        .sst_we_reg (sst_we_reg),
        .sst_dato   (sst_dato),
        .sst_di     (sst_di),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    always #5 clk = ~clk;

    // M2 period 120 ns = 12 clk, offset so its edges never coincide with clk edges
    initial begin
        m2 = 1'b0;
        #3;
        forever begin
            #60;
            m2 = m2_en ? ~m2 : 1'b0;
        end
    end

    assign sst_di = sst_addr ^ 8'h5A;

    always @(negedge m2) begin
        if (sst_act && sst_we_reg) begin
            mem[sst_addr] <= sst_dato;
            if (sst_addr == 8'd0) begin
                prg_reg <= sst_dato[5:4];
                chr_reg <= sst_dato[3:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ld_byte(input int i);
        return (i == 0) ? 8'h2D : 8'(i * 37 + 11);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_act"}, sst_act, 0);
        chk({tag, "_addr"}, sst_addr, 0);
        chk({tag, "_we"}, sst_we_reg, 0);
        chk({tag, "_dato"}, sst_dato, 0);
        chk({tag, "_txdata"}, tx_data, 0);
        chk({tag, "_txvalid"}, tx_valid, 0);
        chk({tag, "_rxready"}, rx_ready, 0);
    endtask

    task automatic run_save(input bit stall, input bit inject_load, input int exp_done_cyc);
        int idx;
        bit got_done;
        bit prev_stall;
        logic [7:0] prev_data;
        idx = 0;
        got_done = 1'b0;
        prev_stall = 1'b0;
        prev_data = 8'd0;
        @(negedge clk);
        cmd_save = 1'b1;
        tx_ready = 1'b1;
        for (int cyc = 1; cyc <= 2000 && !got_done; cyc++) begin
            @(negedge clk);
            cmd_save = 1'b0;
            cmd_load = inject_load && (cyc == 40);
            tx_ready = stall ? (((cyc / 3) % 2) == 0) : 1'b1;
            if (cyc == 1) begin
                chk("save_act_latency", sst_act, 1);
                chk("save_busy", busy, 1);
                chk("save_start_addr", sst_addr, 0);
            end
            if (done) begin
                got_done = 1'b1;
                chk("save_byte_count", idx, REG_CNT);
                if (exp_done_cyc > 0) chk("save_done_cycle", cyc, exp_done_cyc);
                chk("save_done_act", sst_act, 0);
                chk("save_done_busy", busy, 0);
            end else begin
                chk("save_act_held", sst_act, 1);
                if (inject_load) chk("save_no_err", err, 0);
                if (prev_stall) begin
                    chk("save_stall_valid", tx_valid, 1);
                    chk("save_stall_data", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    chk("save_byte", tx_data, 8'(idx) ^ 8'h5A);
                    idx++;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data = tx_data;
            end
        end
        cmd_load = 1'b0;
        chk("save_done_seen", got_done, 1);
        @(negedge clk);
        chk("save_done_pulse", done, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("load_rx_ready_wait", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("load_we_armed", sst_we_reg, 1);
        chk("load_dato", sst_dato, b);
    endtask

    initial begin
        int n;
        int hi;
        bit seen_low;
        rst = 1'b1;
        cmd_save = 1'b0;
        cmd_load = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'd0;
        m2_en = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_save(1'b0, 1'b0, 257);
        run_save(1'b1, 1'b1, -1);

        @(negedge clk);
        cmd_save = 1'b1;
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_save = 1'b0;
        cmd_load = 1'b0;
        chk("dual_err", err, 1);
        chk("dual_busy", busy, 0);
        chk("dual_act", sst_act, 0);
        @(negedge clk);
        chk("dual_err_pulse", err, 0);
        chk("dual_idle", busy, 0);

        m2_en = 1'b1;
        @(negedge clk);
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        chk("load_act", sst_act, 1);
        chk("load_busy", busy, 1);
        for (int i = 0; i < REG_CNT; i++) send_byte(ld_byte(i));
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("load_done", done, 1);
        chk("load_done_busy", busy, 0);
        chk("load_done_act", sst_act, 0);
        repeat (4) @(negedge clk);
        for (int a = 0; a < REG_CNT; a++) chk("load_mem", mem[a], ld_byte(a));
        chk("load_prg", prg_reg, 2'b10);
        chk("load_chr", chr_reg, 4'hD);
        chk("load_idx_reg", mem[SST_MAP_IDX_ADDR], ld_byte(127));

        m2_en = 1'b0;
        repeat (12) @(negedge clk);
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        send_byte(8'h77);
        n = 0;
        while (sst_we_reg && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("to_cycles", n, 4096);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_act", sst_act, 0);
        chk("to_we", sst_we_reg, 0);
        chk("to_done", done, 0);
        @(negedge clk);
        chk("to_err_pulse", err, 0);
        chk("to_no_done", done, 0);

        m2_en = 1'b1;
        @(negedge clk);
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        seen_low = 1'b0;
        hi = 0;
        n = 0;
        while (hi < 4 && n < 300) begin
            if (sst_addr == 8'd5 && sst_we_reg) begin
                if (!m2) begin
                    seen_low = 1'b1;
                    hi = 0;
                end else if (seen_low) begin
                    hi++;
                end
            end
            if (hi < 4) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rst_reached_fall", hi, 4);
        chk("rst_pre_addr", sst_addr, 5);
        chk("rst_pre_we", sst_we_reg, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        m2_en = 1'b0;
        run_save(1'b0, 1'b0, 257);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
